// File: rtl/fp32_accum_ctrl.sv
// Packet accumulator controller: streams FP32 beats through an external combinational adder,
// keeps the running sum, beat count and sticky NaN/Inf/overflow flags, and emits the packet total.
module fp32_accum_ctrl #(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_addent,
    output logic [31:0]      add_augend,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_inf,
    output logic             out_ovf
);

    localparam int unsigned     WAIT_W  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       addent_q, addent_d;
    logic [31:0]       augend_q, augend_d;
    logic              last_q, last_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic in_hs;
    logic out_hs;
    logic res_exp_ff;
    logic res_frac_nz;

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        ovf_d       = ovf_q;
        addent_d    = addent_q;
        augend_d    = augend_q;
        last_d      = last_q;
        wait_d      = wait_q;

        in_hs       = in_valid && in_ready_q;
        out_hs      = out_valid_q && out_ready;
        res_exp_ff  = &add_result[30:23];
        res_frac_nz = |add_result[22:0];

        case (state_q)
            S_RUN: begin
                if (in_hs) begin
                    addent_d = acc_q;
                    augend_d = in_data;
                    last_d   = in_last;
                    wait_d   = WAIT_W'(ADD_LAT - 1);
                    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d    = ovf_q | (cnt_d == CNT_MAX);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    acc_d   = add_result;
                    nan_d   = nan_q | (res_exp_ff & res_frac_nz);
                    inf_d   = inf_q | (res_exp_ff & ~res_frac_nz);
                    state_d = last_q ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (out_hs) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    nan_d   = 1'b0;
                    inf_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        // out_valid is presented one cycle after the final sum lands in acc
        in_ready_d  = (state_d == S_RUN);
        out_valid_d = (state_q == S_DONE) && !out_hs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            acc_q       <= '0;
            cnt_q       <= '0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            ovf_q       <= 1'b0;
            addent_q    <= '0;
            augend_q    <= '0;
            last_q      <= 1'b0;
            wait_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            ovf_q       <= ovf_d;
            addent_q    <= addent_d;
            augend_q    <= augend_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign add_addent = addent_q;
    assign add_augend = augend_q;
    assign out_sum    = acc_q;
    assign out_count  = cnt_q;
    assign out_nan    = nan_q;
    assign out_inf    = inf_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_fp32_accum_ctrl.sv
// Bench for fp32_accum_ctrl: three instances (ADD_LAT=1, ADD_LAT=3, CNT_W=2) fed by a
// behavioural FP32 adder; table vectors, corner sequences and randomized packets vs a model.
module tb_fp32_accum_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [3];
    logic        in_last   [3];
    logic        out_ready [3];
    logic [31:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_nan   [3];
    logic        out_inf   [3];
    logic        out_ovf   [3];
    logic [31:0] addent    [3];
    logic [31:0] augend    [3];
    logic [31:0] result    [3];
    logic [31:0] out_sum   [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [31:0] pipe_a, pipe_b;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] cnt;
        logic        nan;
        logic        inf;
        logic        ovf;
    } res_t;

    typedef struct {
        int              n;
        logic [3:0][31:0] d;
        logic            chk_sum;
        logic [31:0]     sum;
        logic [31:0]     cnt;
        logic            nan;
        logic            inf;
    } vec_t;

    fp32_accum_ctrl #(.ADD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .add_addent(addent[0]),
        .add_augend(augend[0]), .add_result(result[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(out_sum[0]), .out_count(cnt0),
        .out_nan(out_nan[0]), .out_inf(out_inf[0]), .out_ovf(out_ovf[0]));

    fp32_accum_ctrl #(.ADD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .add_addent(addent[1]),
        .add_augend(augend[1]), .add_result(result[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(out_sum[1]), .out_count(cnt1),
        .out_nan(out_nan[1]), .out_inf(out_inf[1]), .out_ovf(out_ovf[1]));

    fp32_accum_ctrl #(.ADD_LAT(1), .CNT_W(2)) u_cnt2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .add_addent(addent[2]),
        .add_augend(augend[2]), .add_result(result[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sum(out_sum[2]), .out_count(cnt2),
        .out_nan(out_nan[2]), .out_inf(out_inf[2]), .out_ovf(out_ovf[2]));

    // FP32 <-> real conversions (normals, zeros, Inf, NaN; subnormals flush to zero)
    function automatic real to_real(input logic [31:0] b);
        logic [7:0]  e;
        logic [63:0] d;
        e = b[30:23];
        if (e == 8'hFF)
            d = {b[31], 11'h7FF, (b[22:0] != 23'h0) ? 52'h8000000000000 : 52'h0};
        else if (e == 8'h00)
            d = {b[31], 63'h0};
        else
            d = {b[31], 11'(32'(e) + 32'd896), b[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047) return {d[63], 8'hFF, (d[51:0] != 52'h0) ? 23'h400000 : 23'h0};
        if (e == 0) return {d[63], 31'h0};
        e = e - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e <= 0) return {d[63], 31'h0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) + to_real(b));
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'h0);
    endfunction

    // Adder model: combinational for ADD_LAT=1, two extra register stages for ADD_LAT=3
    assign result[0] = fp_add(addent[0], augend[0]);
    assign result[2] = fp_add(addent[2], augend[2]);
    always @(posedge clk) begin
        pipe_a <= fp_add(addent[1], augend[1]);
        pipe_b <= pipe_a;
    end
    assign result[1] = pipe_b;

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Offer one beat; garbage is driven while the DUT is not ready and must be ignored
    task automatic send_beat(input int k, input logic [31:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready[k] && guard < 50) begin
            in_valid[k] = 1'($urandom);
            in_data[k]  = $urandom;
            in_last[k]  = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        if (!in_ready[k]) check("in_ready_timeout", 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = l;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_data[k]  = $urandom;
        in_last[k]  = 1'b0;
    endtask

    // Wait for the sum, hold off for 'hold' cycles checking stability, then accept it
    task automatic recv(input int k, input int hold, output res_t r);
        int guard;
        guard = 0;
        @(negedge clk);
        out_ready[k] = 1'b0;
        while (!out_valid[k] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", 32'(out_valid[k]), 32'd1);
        r.sum = out_sum[k];
        r.cnt = cnt_of(k);
        r.nan = out_nan[k];
        r.inf = out_inf[k];
        r.ovf = out_ovf[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid_ready_stable",
                  {29'h0, out_valid[k], in_ready[k], (out_sum[k] == r.sum) && (cnt_of(k) == r.cnt)},
                  32'b101);
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic check_res(input string nm, input res_t r, input logic [31:0] sum,
                             input logic chk_sum, input logic [31:0] cnt,
                             input logic nan, input logic inf, input logic ovf);
        if (chk_sum) check({nm, "_sum"}, r.sum, sum);
        check({nm, "_cnt"}, r.cnt, cnt);
        check({nm, "_flags"}, {29'h0, r.nan, r.inf, r.ovf}, {29'h0, nan, inf, ovf});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        res_t        r;
        int          n;
        logic [31:0] acc, d;
        logic        m_nan, m_inf;
        logic [31:0] beats [6];

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_last[k]   = 1'b0;
            in_data[k]   = 32'h0;
            out_ready[k] = 1'b0;
        end
        rst_n = 1'b0;

        vecs[0] = '{3, {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, 1'b1, 32'h40C00000, 32'd3, 1'b0, 1'b0};
        vecs[1] = '{1, {32'h0, 32'h0, 32'h0, 32'h3FC00000}, 1'b1, 32'h3FC00000, 32'd1, 1'b0, 1'b0};
        vecs[2] = '{2, {32'h0, 32'h0, 32'hFF800000, 32'h7F800000}, 1'b0, 32'h0, 32'd2, 1'b1, 1'b1};
        vecs[3] = '{1, {32'h0, 32'h0, 32'h0, 32'h7F800000}, 1'b1, 32'h7F800000, 32'd1, 1'b0, 1'b1};
        vecs[4] = '{2, {32'h0, 32'h0, 32'hC0400000, 32'h40A00000}, 1'b1, 32'h40000000, 32'd2, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_ready_valid", {30'h0, in_ready[k], out_valid[k]}, 32'h0);
            check("rst_operands", addent[k] | augend[k], 32'h0);
            check("rst_sum_cnt", out_sum[k] | cnt_of(k), 32'h0);
            check("rst_flags", {29'h0, out_nan[k], out_inf[k], out_ovf[k]}, 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(in_ready[0]), 32'd1);

        // Table vectors on the ADD_LAT=1 instance
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++)
                send_beat(0, vecs[v].d[i], i == vecs[v].n - 1);
            recv(0, 0, r);
            check_res($sformatf("vec%0d", v), r, vecs[v].sum, vecs[v].chk_sum,
                      vecs[v].cnt, vecs[v].nan, vecs[v].inf, 1'b0);
        end

        // Last-beat to out_valid latency (ADD_LAT=1 -> 2 cycles)
        send_beat(0, 32'h3FC00000, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_cycles", 32'(n), 32'd2);
        recv(0, 0, r);
        check_res("latency", r, 32'h3FC00000, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);

        // Backpressure for 5 cycles, then next packet starts from +0
        send_beat(0, 32'h40400000, 1'b0);
        send_beat(0, 32'h40400000, 1'b1);
        recv(0, 5, r);
        check_res("bp", r, 32'h40C00000, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        send_beat(0, 32'h40000000, 1'b1);
        recv(0, 0, r);
        check_res("bp_next", r, 32'h40000000, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);

        // ADD_LAT=3: in_ready low exactly 3 cycles after each non-final accept
        for (int i = 0; i < 2; i++) begin
            send_beat(1, 32'h3F800000, 1'b0);
            n = 0;
            while (!in_ready[1] && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("lat3_ready_low", 32'(n), 32'd3);
        end
        send_beat(1, 32'h3F800000, 1'b1);
        recv(1, 2, r);
        check_res("lat3", r, 32'h40400000, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);

        // Reset pulse mid-S_WAIT discards the packet
        send_beat(1, 32'h3F800000, 1'b0);
        send_beat(1, 32'h40000000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready_valid", {30'h0, in_ready[1], out_valid[1]}, 32'h0);
        check("midrst_addent", addent[1], 32'h0);
        check("midrst_augend", augend[1], 32'h0);
        check("midrst_cnt", cnt_of(1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(1, 32'h40000000, 1'b1);
        recv(1, 0, r);
        check_res("midrst_next", r, 32'h40000000, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);

        // CNT_W=2: count saturates at 3 and sets overflow; next packet clears it
        for (int i = 0; i < 5; i++) send_beat(2, 32'h3F800000, i == 4);
        recv(2, 0, r);
        check_res("sat", r, 32'h40A00000, 1'b1, 32'd3, 1'b0, 1'b0, 1'b1);
        send_beat(2, 32'h3F800000, 1'b0);
        send_beat(2, 32'h3F800000, 1'b1);
        recv(2, 0, r);
        check_res("sat_next", r, 32'h40000000, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);

        // Randomized packets against the reference model
        for (int p = 0; p < 30; p++) begin
            int k;
            k = p % 2;
            n = int'($urandom_range(1, 6));
            acc   = 32'h0;
            m_nan = 1'b0;
            m_inf = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0)
                    d = {1'($urandom), 31'h7F800000};
                else
                    d = from_real(real'(int'($urandom_range(0, 1000)) - 500));
                beats[i] = d;
                acc   = fp_add(acc, d);
                m_nan = m_nan | is_nan(acc);
                m_inf = m_inf | is_inf(acc);
            end
            for (int i = 0; i < n; i++) send_beat(k, beats[i], i == n - 1);
            recv(k, int'($urandom_range(0, 3)), r);
            check_res($sformatf("rand%0d", p), r, acc, 1'b1, 32'(n), m_nan, m_inf, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
